retire_trace_buffer: RTL and testbench

//  Sits directly downstream of the cpu writeback/memory stage and consumes its per-cycle

---
 rtl/retire_trace_buffer.sv | 169 ++++++++++++++++
 tb/tb_retire_trace_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// rtl/retire_trace_buffer.sv - commit trace capture FIFO with counters, halt/timeout detection; optional TRACE_STALL_EN
module retire_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trace_en,
    input  logic [15:0]      pc,
    input  logic             reg_write,
    input  logic [3:0]       write_reg,
    input  logic [15:0]      write_data,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_data,
    input  logic             halt,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [54:0]      rec_data,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count,
    output logic [15:0]      drop_count,
    output logic             halted,
    output logic             done,
    output logic             timeout,
    output logic             stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [54:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   inst_q, inst_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [15:0]        drop_q, drop_d;
    logic               halted_q, halted_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;

    logic               full, pop, push, drop, capture, stall;
    logic [1:0]         kind;
    logic [3:0]         rec_reg;
    logic [15:0]        rec_value, rec_addr;
    logic [54:0]        rec_in;

    // Stall holds the cpu only while running against a full FIFO.
`ifdef TRACE_STALL_EN
    assign stall = (state_q == S_RUN) && full;
`else
    assign stall = 1'b0;
`endif

    // Record packing and FIFO push/pop qualification.
    always_comb begin
        full      = (occ_q == DEPTH_C);
        pop       = (occ_q != '0) && rec_ready;
        capture   = (state_q == S_RUN) && trace_en && !stall;
        push      = capture && (!full || pop);
        drop      = capture && full && !pop;
        kind      = halt ? 2'b11 : reg_write ? 2'b01 : mem_write ? 2'b10 : 2'b00;
        rec_reg   = (kind == 2'b01) ? write_reg : 4'd0;
        rec_value = (kind == 2'b01) ? write_data : (kind == 2'b10) ? mem_data : 16'd0;
        rec_addr  = (mem_read || mem_write) ? mem_addr : 16'd0;
        rec_in    = {kind, reg_write & mem_read, rec_reg, pc, rec_value, rec_addr};
        occ_d     = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // FSM next state plus counter and sticky-flag updates; counters only move in RUN.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        cyc_d     = cyc_q;
        drop_d    = drop_q;
        halted_d  = halted_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (trace_en) state_d = S_RUN;
            end
            S_RUN: begin
                if (!trace_en) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                    if (capture) begin
                        inst_d = inst_q + CNT_W'(1);
                        if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                        if (halt) begin
                            halted_d = 1'b1;
                            state_d  = S_HALTED;
                        end
                    end
                    // Runaway detection wins over a same-cycle halt.
                    if (cyc_d == MAX_C) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                if (occ_d == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // State, pointer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            inst_q    <= '0;
            cyc_q     <= '0;
            drop_q    <= '0;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_q + PTR_W'(push);
            rd_ptr_q  <= rd_ptr_q + PTR_W'(pop);
            occ_q     <= occ_d;
            inst_q    <= inst_d;
            cyc_q     <= cyc_d;
            drop_q    <= drop_d;
            halted_q  <= halted_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    // Record storage; pointer reset alone discards stale contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rec_in;
    end

    assign rec_valid   = (occ_q != '0);
    assign rec_data    = mem_q[rd_ptr_q];
    assign inst_count  = inst_q;
    assign cycle_count = cyc_q;
    assign drop_count  = drop_q;
    assign halted      = halted_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign stall_req   = stall;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb/tb_retire_trace_buffer.sv - randomized model-based bench for retire_trace_buffer
module tb_retire_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int MAXC  = 200;
`ifdef TRACE_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, trace_en, reg_write, mem_read, mem_write, halt, rec_ready;
    logic [15:0]      pc, write_data, mem_addr, mem_data;
    logic [3:0]       write_reg;
    logic             rec_valid, halted, done, timeout, stall_req;
    logic [54:0]      rec_data;
    logic [CNT_W-1:0] inst_count, cycle_count;
    logic [15:0]      drop_count;

    retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .pc(pc), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .inst_count(inst_count), .cycle_count(cycle_count), .drop_count(drop_count),
        .halted(halted), .done(done), .timeout(timeout), .stall_req(stall_req)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 run, 2 halted, 3 done
    logic [54:0] mq[$];
    int          m_state;
    longint      m_inst, m_cyc;
    int          m_drop;
    bit          m_halted, m_done, m_timeout;

    function automatic logic [54:0] make_rec();
        logic [1:0]  k;
        logic [15:0] v, a;
        logic [3:0]  r;
        if (halt) k = 2'b11;
        else if (reg_write) k = 2'b01;
        else if (mem_write) k = 2'b10;
        else k = 2'b00;
        v = (k == 2'b01) ? write_data : (k == 2'b10) ? mem_data : 16'h0;
        r = (k == 2'b01) ? write_reg : 4'h0;
        a = (mem_read || mem_write) ? mem_addr : 16'h0;
        return {k, reg_write & mem_read, r, pc, v, a};
    endfunction

    task automatic model_step();
        int sz, nstate;
        bit pop, push;
        logic [54:0] rec;
        if (rst) begin
            mq.delete();
            m_state = 0; m_inst = 0; m_cyc = 0; m_drop = 0;
            m_halted = 0; m_done = 0; m_timeout = 0;
            return;
        end
        sz = mq.size();
        pop = (sz > 0) && rec_ready;
        push = 0;
        nstate = m_state;
        rec = make_rec();
        if (m_state == 0) begin
            if (trace_en) nstate = 1;
        end else if (m_state == 1) begin
            if (!trace_en) nstate = 0;
            else begin
                m_cyc++;
                if (!(STALL && sz == DEPTH)) begin
                    m_inst++;
                    if (sz < DEPTH || pop) push = 1;
                    else if (m_drop < 65535) m_drop++;
                    if (halt) begin m_halted = 1; nstate = 2; end
                end
                if (m_cyc == MAXC) begin nstate = 3; m_timeout = 1; m_done = 1; end
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(rec);
        if (m_state == 2 && mq.size() == 0) begin nstate = 3; m_done = 1; end
        m_state = nstate;
    endtask

    task automatic check_all();
        check("rec_valid", rec_valid, mq.size() != 0);
        if (mq.size() != 0) check("rec_data", rec_data, mq[0]);
        check("inst_count", inst_count, m_inst);
        check("cycle_count", cycle_count, m_cyc);
        check("drop_count", drop_count, m_drop);
        check("halted", halted, m_halted);
        check("done", done, m_done);
        check("timeout", timeout, m_timeout);
        check("stall_req", stall_req, STALL && m_state == 1 && mq.size() == DEPTH);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic zero_inputs();
        trace_en = 0; reg_write = 0; mem_read = 0; mem_write = 0; halt = 0; rec_ready = 0;
        pc = 0; write_data = 0; mem_addr = 0; mem_data = 0; write_reg = 0;
    endtask

    task automatic rand_inputs(input int ready_pct, input int halt_pct);
        trace_en   = ($urandom_range(0, 99) < 92);
        reg_write  = ($urandom_range(0, 99) < 40);
        mem_read   = ($urandom_range(0, 99) < 30);
        mem_write  = ($urandom_range(0, 99) < 30);
        halt       = ($urandom_range(0, 999) < halt_pct);
        rec_ready  = ($urandom_range(0, 99) < ready_pct);
        pc         = 16'($urandom);
        write_data = 16'($urandom);
        mem_addr   = 16'($urandom);
        mem_data   = 16'($urandom);
        write_reg  = 4'($urandom);
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    int ready_tbl[4] = '{15, 50, 85, 100};

    initial begin
        zero_inputs();
        mq.delete();
        m_state = 0; m_inst = 0; m_cyc = 0; m_drop = 0;
        m_halted = 0; m_done = 0; m_timeout = 0;
        rst = 1;
        cycle();
        cycle();
        check("reset_inst", inst_count, 0);
        check("reset_valid", rec_valid, 0);
        rst = 0;

        // single register write record
        trace_en = 1; reg_write = 1; write_reg = 4'd3; write_data = 16'h00AB; pc = 16'h0002;
        cycle();
        cycle();
        check("t1_rec", rec_data, {2'b01, 1'b0, 4'd3, 16'h0002, 16'h00AB, 16'h0000});
        check("t1_inst", inst_count, 1);

        // store, then load into register
        reg_write = 0; mem_write = 1; mem_addr = 16'h0010; mem_data = 16'h1234; pc = 16'h0004;
        rec_ready = 1;
        cycle();
        check("t2_store", rec_data, {2'b10, 1'b0, 4'd0, 16'h0004, 16'h1234, 16'h0010});
        mem_write = 0; reg_write = 1; mem_read = 1; write_reg = 4'd5; write_data = 16'h0077;
        mem_addr = 16'h0020; pc = 16'h0006;
        cycle();
        check("t2_load", rec_data, {2'b01, 1'b1, 4'd5, 16'h0006, 16'h0077, 16'h0020});

        // overflow with reader stopped
        zero_inputs();
        do_reset();
        trace_en = 1;
        cycle();
        for (int i = 0; i < DEPTH + 3; i++) begin
            reg_write = 1; write_reg = 4'($urandom); write_data = 16'($urandom); pc = 16'(i);
            cycle();
        end
        check("t3_drop", drop_count, STALL ? 0 : 3);
        check("t3_inst", inst_count, STALL ? DEPTH : DEPTH + 3);
        // simultaneous push and pop while full
        rec_ready = 1;
        cycle();
        check("t6_drop", drop_count, STALL ? 0 : 3);

        // halt with five records queued
        zero_inputs();
        do_reset();
        trace_en = 1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            mem_write = 1; mem_addr = 16'($urandom); mem_data = 16'($urandom);
            cycle();
        end
        mem_write = 0; halt = 1;
        cycle();
        check("t4_halted", halted, 1);
        halt = 0; rec_ready = 1;
        for (int i = 0; i < 12; i++) begin
            reg_write = 1; write_data = 16'($urandom);
            cycle();
        end
        check("t4_done", done, 1);
        check("t4_inst", inst_count, 6);

        // runaway timeout
        zero_inputs();
        do_reset();
        for (int i = 0; i < MAXC + 5; i++) begin
            rand_inputs(100, 0);
            trace_en = 1;
            cycle();
        end
        check("t5_timeout", timeout, 1);
        check("t5_cycles", cycle_count, MAXC);

        // randomized episodes with occasional mid-run reset
        for (int ep = 0; ep < 8; ep++) begin
            zero_inputs();
            do_reset();
            for (int i = 0; i < 400; i++) begin
                rand_inputs(ready_tbl[ep % 4], (ep < 4) ? 3 : 15);
                rst = ($urandom_range(0, 299) == 0);
                cycle();
            end
            rst = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
